acq_fifo_ctrl: RTL

ACQ_FIFO_CTRL -- requirements
Module: acq_fifo_ctrl

---
 rtl/acq_fifo_ctrl_pkg.sv | 17 +
 rtl/acq_fifo_ctrl_trig_detect.sv | 46 ++++
 rtl/acq_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/acq_fifo_ctrl_pkg.sv
// Shared definitions for the acquisition FIFO controller: state encoding,
// default widths and the FLUSH settle count.
package acq_fifo_ctrl_pkg;

  localparam int unsigned DATA_W_DEF   = 12;
  localparam int unsigned LEN_W_DEF    = 12;
  localparam int unsigned FLUSH_SETTLE = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_FLUSH   = 3'd4
  } state_e;

endpackage

// File: rtl/acq_fifo_ctrl_trig_detect.sv
// Rising level-crossing detector for the ARM trigger; only built when
// TRIG_LEVEL_EN is defined.
`ifdef TRIG_LEVEL_EN
module trig_detect
  import acq_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] trig_level,
  output logic              cross
);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;

  // Remember the last valid sample so a crossing needs a real predecessor.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (adc_valid) begin
      prev_d     = adc_data;
      prev_vld_d = 1'b1;
    end else begin
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= {DATA_W{1'b0}};
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign cross = adc_valid && prev_vld_q && (prev_q < trig_level) && (trig_level <= adc_data);

endmodule
`endif

// File: rtl/acq_fifo_ctrl.sv
// Acquisition controller: captures a triggered burst of ADC samples into an
// external FIFO, then drains it onto a valid/ready stream. Optional level
// trigger is enabled with the TRIG_LEVEL_EN macro.
module acq_fifo_ctrl
  import acq_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  sample_len,
  input  logic              trig,
`ifdef TRIG_LEVEL_EN
  input  logic [DATA_W-1:0] trig_level,
`endif
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [2:0]       FLUSH_LAST = 3'(FLUSH_SETTLE - 1);
  localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]  wr_ok_q, wr_ok_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              ovf_q, ovf_d;
  logic              rd_fl_q, rd_fl_d;
  logic [2:0]        empty_cnt_q, empty_cnt_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              done_q, done_d;
  logic              rd_en_s;
  logic              trig_cond_s;
  logic [LEN_W-1:0]  target_s;
  logic [LEN_W-1:0]  wr_inc_s;

`ifdef TRIG_LEVEL_EN
  logic cross_s;

  trig_detect #(.DATA_W(DATA_W)) u_trig_detect (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .trig_level (trig_level),
    .cross      (cross_s)
  );

  assign trig_cond_s = trig || cross_s;
`else
  assign trig_cond_s = trig;
`endif

  // After an overflow only the samples that actually reached the FIFO come back.
  assign target_s = ovf_q ? wr_ok_q : len_q;
  assign wr_inc_s = wr_cnt_q + LEN_ONE;

  // Next-state and datapath update; abort wins over every other transition.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_cnt_d    = wr_cnt_q;
    wr_ok_d     = wr_ok_q;
    rd_cnt_d    = rd_cnt_q;
    ovf_d       = ovf_q;
    rd_fl_d     = 1'b0;
    empty_cnt_d = empty_cnt_q;
    din_d       = din_q;
    wr_en_d     = 1'b0;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    done_d      = 1'b0;
    rd_en_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (sample_len != {LEN_W{1'b0}})) begin
          state_d  = ST_ARM;
          len_d    = sample_len;
          wr_cnt_d = {LEN_W{1'b0}};
          wr_ok_d  = {LEN_W{1'b0}};
          rd_cnt_d = {LEN_W{1'b0}};
          ovf_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARM: begin
        if (abort) begin
          state_d     = ST_FLUSH;
          empty_cnt_d = 3'd0;
        end else if (trig_cond_s) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_ARM;
        end
      end

      ST_CAPTURE: begin
        if (abort) begin
          state_d     = ST_FLUSH;
          empty_cnt_d = 3'd0;
        end else if (adc_valid) begin
          wr_cnt_d = wr_inc_s;
          if (!fifo_full) begin
            wr_en_d = 1'b1;
            din_d   = adc_data;
            wr_ok_d = wr_ok_q + LEN_ONE;
          end else begin
            ovf_d = 1'b1;
          end
          if (wr_inc_s == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_DRAIN: begin
        if (abort) begin
          state_d     = ST_FLUSH;
          m_valid_d   = 1'b0;
          empty_cnt_d = 3'd0;
        end else begin
          // One read in flight at a time; data lands in m_data the next cycle.
          rd_en_s = !fifo_empty && (rd_cnt_q < target_s) && !rd_fl_q && (!m_valid_q || m_ready);
          rd_fl_d = rd_en_s;
          if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
          end else begin
            m_valid_d = m_valid_q;
          end
          if (rd_fl_q) begin
            m_data_d  = fifo_dout;
            m_valid_d = 1'b1;
            rd_cnt_d  = rd_cnt_q + LEN_ONE;
          end else begin
            m_data_d = m_data_q;
          end
          if ((rd_cnt_q == target_s) && !rd_fl_q && (!m_valid_q || m_ready)) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            m_valid_d = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_FLUSH: begin
        rd_en_s   = !fifo_empty;
        m_valid_d = 1'b0;
        // Wait out the FIFO's flag latency before declaring it drained.
        if (fifo_empty) begin
          if (empty_cnt_q == FLUSH_LAST) begin
            state_d     = ST_IDLE;
            empty_cnt_d = 3'd0;
          end else begin
            empty_cnt_d = empty_cnt_q + 3'd1;
          end
        end else begin
          empty_cnt_d = 3'd0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= {LEN_W{1'b0}};
      wr_cnt_q    <= {LEN_W{1'b0}};
      wr_ok_q     <= {LEN_W{1'b0}};
      rd_cnt_q    <= {LEN_W{1'b0}};
      ovf_q       <= 1'b0;
      rd_fl_q     <= 1'b0;
      empty_cnt_q <= 3'd0;
      din_q       <= {DATA_W{1'b0}};
      wr_en_q     <= 1'b0;
      m_data_q    <= {DATA_W{1'b0}};
      m_valid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_ok_q     <= wr_ok_d;
      rd_cnt_q    <= rd_cnt_d;
      ovf_q       <= ovf_d;
      rd_fl_q     <= rd_fl_d;
      empty_cnt_q <= empty_cnt_d;
      din_q       <= din_d;
      wr_en_q     <= wr_en_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      done_q      <= done_d;
    end
  end

  assign fifo_din   = din_q;
  assign fifo_wr_en = wr_en_q;
  assign fifo_rd_en = rd_en_s;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
